// File: rtl/ad7989_pkg.sv
// rtl/ad7989_pkg.sv - shared types and constants for the AD7989 capture block
//
// Purpose : state encoding, word layout constants and the FIFO word packer
//           shared by ad7989_capture and ad7989_sck_shift.
// Ports   : none (package).
package ad7989_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int DATA_BITS  = 18;
  localparam int TAG_MSB    = 31;
  localparam int TAG_LSB    = 24;
  localparam int TAG_W      = TAG_MSB - TAG_LSB + 1;
  localparam int SAMPLE_MSB = 17;
  localparam int SCK_PULSES = 18;

  // FIFO word: [31:24] tag, [23:18] zero, [17:0] sample.
  function automatic logic [31:0] pack_word(input logic [TAG_W-1:0]     tag,
                                            input logic [DATA_BITS-1:0] sample);
    logic [31:0] w;
    w                   = '0;
    w[TAG_MSB:TAG_LSB]  = tag;
    w[SAMPLE_MSB:0]     = sample;
    return w;
  endfunction

endpackage

// File: rtl/ad7989_sck_shift.sv
// rtl/ad7989_sck_shift.sv - SCK generator and SDO shift register for one AD7989 readout
//
// Purpose : on start, emits 18 SCK pulses (SCK_HALF cycles low, then SCK_HALF
//           cycles high) and shifts ADC_SDO in MSB first on the last cycle of
//           each high phase.
// Ports   : CLK, RST       - clock, async active-high reset
//           start          - one-cycle pulse, readout begins next cycle
//           sdo            - ADC serial data
//           sck            - registered serial clock, idles low
//           sample_next    - shift register contents including the bit being sampled now
//           done           - high on the cycle the final bit is sampled
module ad7989_sck_shift
  import ad7989_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 sdo,
  output logic                 sck,
  output logic [DATA_BITS-1:0] sample_next,
  output logic                 done
);

  localparam logic [3:0] HALF_END  = 4'(SCK_HALF - 1);
  localparam logic [4:0] LAST_PULSE = 5'(SCK_PULSES - 1);

  logic                 active_q;
  logic                 sck_q;
  logic [3:0]           div_q;
  logic [4:0]           pulse_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 half_end;

  assign half_end    = (div_q == HALF_END);
  assign sample_next = {shift_q[DATA_BITS-2:0], sdo};
  // Final bit is sampled combinationally so the parent can register the
  // complete word on the same edge that ends the readout.
  assign done        = active_q && sck_q && half_end && (pulse_q == LAST_PULSE);
  assign sck         = sck_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      pulse_q  <= '0;
      shift_q  <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      sck_q    <= 1'b0;
      div_q    <= '0;
      pulse_q  <= '0;
    end else if (active_q) begin
      if (half_end) begin
        div_q <= '0;
        sck_q <= ~sck_q;
        if (sck_q) begin
          // End of a high phase: capture SDO just before SCK falls.
          shift_q <= sample_next;
          if (pulse_q == LAST_PULSE) begin
            active_q <= 1'b0;
          end else begin
            pulse_q <= pulse_q + 5'd1;
          end
        end
      end else begin
        div_q <= div_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ad7989_capture.sv
// rtl/ad7989_capture.sv - AD7989 3-wire conversion/readout driver feeding the sample FIFO
//
// Purpose : paces conversions at SAMPLE_PERIOD, holds ADC_CNV for CONV_CYCLES,
//           reads 18 bits via ad7989_sck_shift, and writes one tagged 32-bit
//           word per conversion, counting words dropped on FIFO_FULL.
// Ports   : CLK, RST      - 100 MHz clock, async active-high reset
//           EN            - sampling enable
//           ADC_CNV       - convert start, high during conversion
//           ADC_SCK       - serial clock, idles low
//           ADC_SDO       - ADC serial data, MSB first
//           FIFO_DATA     - {tag, 6'b0, sample}
//           FIFO_WR_EN    - one-cycle write strobe
//           FIFO_FULL     - FIFO full flag
//           BUSY          - high whenever not IDLE
//           OVERFLOW_CNT  - dropped samples, saturating
module ad7989_capture
  import ad7989_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 250,
  parameter int CONV_CYCLES   = 160,
  parameter int SCK_HALF      = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        ADC_CNV,
  output logic        ADC_SCK,
  input  logic        ADC_SDO,
  output logic [31:0] FIFO_DATA,
  output logic        FIFO_WR_EN,
  input  logic        FIFO_FULL,
  output logic        BUSY,
  output logic [15:0] OVERFLOW_CNT
);

  localparam int CNT_W  = $clog2(SAMPLE_PERIOD + 1);
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CONV_W-1:0]    conv_cnt_q;
  logic                 cnv_q;
  logic                 wr_q;
  logic                 busy_q;
  logic [31:0]          data_q;
  logic [TAG_W-1:0]     tag_q;
  logic [15:0]          overflow_q;

  logic                 start;
  logic                 conv_last;
  logic                 read_start;
  logic                 read_done;
  logic [DATA_BITS-1:0] sample_next;

  assign start      = EN && (cnt_q == '0) && (state_q == IDLE);
  assign conv_last  = (conv_cnt_q == CONV_LAST);
  assign read_start = (state_q == CONV) && conv_last;

  // Sample-rate timebase; parked at 0 while disabled so re-enabling starts
  // a conversion on the very next edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (!EN || (cnt_q == CNT_LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  ad7989_sck_shift #(
    .SCK_HALF (SCK_HALF)
  ) u_sck_shift (
    .CLK         (CLK),
    .RST         (RST),
    .start       (read_start),
    .sdo         (ADC_SDO),
    .sck         (ADC_SCK),
    .sample_next (sample_next),
    .done        (read_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      conv_cnt_q <= '0;
      cnv_q      <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      tag_q      <= '0;
      overflow_q <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CONV;
            cnv_q      <= 1'b1;
            conv_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        CONV: begin
          if (conv_last) begin
            state_q <= READ;
            cnv_q   <= 1'b0;
          end else begin
            conv_cnt_q <= conv_cnt_q + 1'b1;
          end
        end
        READ: begin
          // The write decision is taken on the final READ edge so that both
          // the strobe and the word are flops during the WRITE cycle.
          if (read_done) begin
            state_q <= WRITE;
            if (!FIFO_FULL) begin
              wr_q   <= 1'b1;
              data_q <= pack_word(tag_q, sample_next);
            end else if (overflow_q != 16'hFFFF) begin
              overflow_q <= overflow_q + 16'd1;
            end
          end
        end
        WRITE: begin
          // Tag advances on dropped words too, leaving visible gaps.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tag_q   <= tag_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ADC_CNV      = cnv_q;
  assign FIFO_WR_EN   = wr_q;
  assign FIFO_DATA    = data_q;
  assign BUSY         = busy_q;
  assign OVERFLOW_CNT = overflow_q;

endmodule

// File: tb/tb_ad7989_capture.sv
// tb/tb_ad7989_capture.sv - directed self-checking bench for ad7989_capture
`timescale 1ns/1ps
module tb_ad7989_capture;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        ADC_SDO = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        ADC_CNV;
  logic        ADC_SCK;
  logic [31:0] FIFO_DATA;
  logic        FIFO_WR_EN;
  logic        BUSY;
  logic [15:0] OVERFLOW_CNT;

  ad7989_capture dut (
    .CLK          (CLK),
    .RST          (RST),
    .EN           (EN),
    .ADC_CNV      (ADC_CNV),
    .ADC_SCK      (ADC_SCK),
    .ADC_SDO      (ADC_SDO),
    .FIFO_DATA    (FIFO_DATA),
    .FIFO_WR_EN   (FIFO_WR_EN),
    .FIFO_FULL    (FIFO_FULL),
    .BUSY         (BUSY),
    .OVERFLOW_CNT (OVERFLOW_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    int          c;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_log[$];
  logic [17:0] adc_q[$];
  logic [17:0] cur = '0;
  int          idx = 17;
  logic        cnv_prev = 1'b0;
  logic        sck_prev = 1'b0;
  int          cnv_rises = 0;
  int          last_rise = 0;
  int          cnv_high = 0;
  int          sck_rises = 0;
  int          sck_high = 0;

  // Monitor and ADC model: SDO presents bit 17 once CNV falls and steps to
  // the next bit after each SCK falling edge.
  always @(negedge CLK) begin
    if (FIFO_WR_EN === 1'b1) wr_log.push_back('{cyc, FIFO_DATA});
    if (ADC_CNV) cnv_high++;
    if (ADC_CNV && !cnv_prev) begin
      cnv_rises++;
      last_rise = cyc;
    end
    if (ADC_SCK) sck_high++;
    if (ADC_SCK && !sck_prev) sck_rises++;
    if (cnv_prev && !ADC_CNV) begin
      if (adc_q.size() > 0) cur = adc_q.pop_front();
      else cur = '0;
      idx = 17;
      ADC_SDO = cur[idx];
    end else if (sck_prev && !ADC_SCK && idx > 0) begin
      idx--;
      ADC_SDO = cur[idx];
    end
    cnv_prev = ADC_CNV;
    sck_prev = ADC_SCK;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    wr_log.delete();
    cnv_rises = 0;
    cnv_high  = 0;
    sck_rises = 0;
    sck_high  = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    clear_mon();
  endtask

  function automatic logic [31:0] word(input int tag, input logic [17:0] s);
    logic [7:0] t;
    t = 8'(tag);
    return {t, 6'b0, s};
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          l;
    int          k;
    bit          seen;
    logic [17:0] vals[10];

    // Reset state
    do_reset();
    chk("rst_cnv", 32'(ADC_CNV), 0);
    chk("rst_sck", 32'(ADC_SCK), 0);
    chk("rst_wr", 32'(FIFO_WR_EN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_data", FIFO_DATA, 0);
    chk("rst_ovf", 32'(OVERFLOW_CNT), 0);

    // Reset mid-READ
    adc_q.push_back(18'h3FFFF);
    EN = 1'b1;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (ADC_SCK) seen = 1;
    end
    chk("midread_reached", 32'(seen), 1);
    RST = 1'b1;
    EN = 1'b0;
    #1;
    chk("midrst_cnv", 32'(ADC_CNV), 0);
    chk("midrst_sck", 32'(ADC_SCK), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("midrst_nowrite", 32'(wr_log.size()), 0);
    chk("midrst_ovf", 32'(OVERFLOW_CNT), 0);
    chk("midrst_data", FIFO_DATA, 0);
    adc_q.delete();
    clear_mon();

    // Single conversion timing and data
    adc_q.push_back(18'h2A5C3);
    l = cyc;
    EN = 1'b1;
    for (int i = 0; i < 240; i++) tick();
    EN = 1'b0;
    repeat (5) tick();
    chk("single_cnv_rises", 32'(cnv_rises), 1);
    chk("single_cnv_first", 32'(last_rise - l), 1);
    chk("single_cnv_len", 32'(cnv_high), 160);
    chk("single_sck_pulses", 32'(sck_rises), 18);
    chk("single_sck_high", 32'(sck_high), 36);
    chk("single_nwr", 32'(wr_log.size()), 1);
    if (wr_log.size() >= 1) begin
      chk("single_wr_cycle", 32'(wr_log[0].c - l), 233);
      chk("single_data", wr_log[0].d, 32'h0002A5C3);
    end
    chk("single_busy_after", 32'(BUSY), 0);

    // Continuous run of 10 samples
    do_reset();
    vals[0] = 18'h00000;
    vals[1] = 18'h3FFFF;
    for (int i = 2; i < 10; i++) vals[i] = (i % 2 == 0) ? 18'h15555 : 18'h2AAAA;
    for (int i = 0; i < 10; i++) adc_q.push_back(vals[i]);
    l = cyc;
    EN = 1'b1;
    k = 0;
    while (wr_log.size() < 10 && k < 2700) begin
      tick();
      k++;
    end
    EN = 1'b0;
    repeat (30) tick();
    chk("cont_nwr", 32'(wr_log.size()), 10);
    for (int i = 0; i < 10 && i < wr_log.size(); i++) begin
      chk($sformatf("cont_cycle%0d", i), 32'(wr_log[i].c - l), 32'(233 + 250 * i));
      chk($sformatf("cont_data%0d", i), wr_log[i].d, word(i, vals[i]));
    end

    // FIFO full on samples 3 and 4
    do_reset();
    for (int i = 0; i < 6; i++) adc_q.push_back(18'h01234 + 18'(i));
    l = cyc;
    EN = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      FIFO_FULL = (cyc - l >= 750) && (cyc - l < 1250);
      if (cyc - l == 1490) EN = 1'b0;
    end
    FIFO_FULL = 1'b0;
    repeat (10) tick();
    chk("full_nwr", 32'(wr_log.size()), 4);
    chk("full_ovf", 32'(OVERFLOW_CNT), 2);
    if (wr_log.size() == 4) begin
      chk("full_w0", wr_log[0].d, word(0, 18'h01234));
      chk("full_w1", wr_log[1].d, word(1, 18'h01235));
      chk("full_w2", wr_log[2].d, word(2, 18'h01236));
      chk("full_w3_tag5", wr_log[3].d, word(5, 18'h01239));
    end

    // EN dropped 50 cycles into CONV, then re-raised
    do_reset();
    adc_q.push_back(18'h0BEEF);
    l = cyc;
    EN = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cyc - l == 50) EN = 1'b0;
    end
    chk("endrop_nwr", 32'(wr_log.size()), 1);
    if (wr_log.size() >= 1) begin
      chk("endrop_cycle", 32'(wr_log[0].c - l), 233);
      chk("endrop_data", wr_log[0].d, word(0, 18'h0BEEF));
    end
    chk("endrop_one_cnv", 32'(cnv_rises), 1);
    chk("endrop_busy", 32'(BUSY), 0);
    adc_q.push_back(18'h00001);
    l = cyc;
    EN = 1'b1;
    chk("reen_cnv_before", 32'(ADC_CNV), 0);
    tick();
    chk("reen_cnv_after", 32'(ADC_CNV), 1);
    chk("reen_rise_cycle", 32'(last_rise - l), 1);
    EN = 1'b0;
    repeat (250) tick();
    chk("reen_nwr", 32'(wr_log.size()), 2);
    if (wr_log.size() >= 2) chk("reen_data", wr_log[1].d, word(1, 18'h00001));

    // Overflow saturation and tag wrap
    do_reset();
    force dut.overflow_q = 16'hFFFE;
    force dut.tag_q = 8'd254;
    tick();
    release dut.overflow_q;
    release dut.tag_q;
    tick();
    chk("sat_preset", 32'(OVERFLOW_CNT), 32'hFFFE);
    for (int i = 0; i < 4; i++) adc_q.push_back(18'h20000 + 18'(i));
    FIFO_FULL = 1'b1;
    l = cyc;
    EN = 1'b1;
    for (int i = 0; i < 995; i++) begin
      tick();
      if (cyc - l == 240) chk("sat_first", 32'(OVERFLOW_CNT), 32'hFFFF);
      if (cyc - l == 740) begin
        chk("sat_hold", 32'(OVERFLOW_CNT), 32'hFFFF);
        FIFO_FULL = 1'b0;
      end
      if (cyc - l == 990) EN = 1'b0;
    end
    repeat (10) tick();
    chk("sat_final", 32'(OVERFLOW_CNT), 32'hFFFF);
    chk("sat_nwr", 32'(wr_log.size()), 1);
    if (wr_log.size() >= 1) chk("sat_wrap_word", wr_log[0].d, word(1, 18'h20003));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
